// File: rtl/vehicle_sensor_conditioner_pkg.sv
// Shared definitions for the country-road sensor conditioner and the TLC
// controller: light codes on the cntry feedback bus and conditioner states.
`timescale 1ns/1ps
package vehicle_sensor_conditioner_pkg;

    // Country light codes as driven by TLC on cntry
    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // Conditioner FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        PRESENT = 3'd2,
        HOLD    = 3'd3,
        FAULT   = 3'd4
    } cond_state_t;

endpackage

// File: rtl/vehicle_sensor_conditioner_sync_chain.sv
// Reusable reset-to-0 synchroniser chain for a single asynchronous bit.
// q is the last flop; STAGES must be at least 2.
`timescale 1ns/1ps
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic clear_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw bit through the chain, oldest sample at the top
    always_ff @(posedge clock or negedge clear_n) begin
        // NOTE: the chain is a handful of flops, not a memory, so it is
        // reset; that keeps a stale 1 from qualifying a phantom car after
        // reset. Sequential state uses <= so every stage sees the old value.
        if (!clear_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Cleans the raw country-road loop detector into the car-present request X
// for TLC: synchronise, debounce arrival/departure, latch unserved requests
// until the country light goes green, and flag a stuck detector.
`timescale 1ns/1ps
module vehicle_sensor_conditioner
    import vehicle_sensor_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_CYCLES    = 4,
    parameter int MAX_PRESENT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       sensor_raw,
    input  logic [1:0] cntry,
    output logic       X,
    output logic       fault,
    output logic [7:0] car_count
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PRES_W = $clog2(MAX_PRESENT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DEB_FULL = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [PRES_W-1:0] PRES_MAX = PRES_W'(MAX_PRESENT_CYCLES);

    logic              sync;
    cond_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [PRES_W-1:0] pres;
    logic              served;

    logic [CNT_W-1:0]  cnt_inc;
    logic [PRES_W-1:0] pres_inc;
    logic              green;
    logic              served_now;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clock   (clock),
        .clear_n (clear_n),
        .d       (sensor_raw),
        .q       (sync)
    );

    // Saturating counter increments and this cycle's service status
    always_comb begin
        // NOTE: every signal here is assigned on every path, so no latch
        // can be inferred.
        cnt_inc    = (cnt == DEB_FULL) ? cnt : cnt + CNT_W'(1);
        pres_inc   = (pres == PRES_MAX) ? pres : pres + PRES_W'(1);
        green      = (cntry == GREEN);
        served_now = served | green;
    end

    // Conditioner FSM with its counters; X and fault are set from the next state
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pres      <= '0;
            served    <= 1'b0;
            X         <= 1'b0;
            fault     <= 1'b0;
            car_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync) begin
                        state <= QUALIFY;
                        cnt   <= CNT_W'(1);
                    end
                end

                QUALIFY: begin
                    if (!sync) begin
                        // Too short to be a car
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state     <= PRESENT;
                        cnt       <= '0;
                        pres      <= '0;
                        served    <= 1'b0;
                        X         <= 1'b1;
                        car_count <= car_count + 8'd1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                PRESENT: begin
                    served <= served_now;
                    if (sync) begin
                        pres <= pres_inc;
                        cnt  <= '0;
                    end else begin
                        pres <= '0;
                        cnt  <= cnt_inc;
                    end
                    // A stuck detector beats a simultaneous departure
                    if (sync && pres_inc == PRES_MAX) begin
                        state <= FAULT;
                        cnt   <= '0;
                        pres  <= '0;
                        X     <= 1'b0;
                        fault <= 1'b1;
                    end else if (!sync && cnt_inc == DEB_FULL) begin
                        cnt <= '0;
                        if (served_now) begin
                            state <= IDLE;
                            X     <= 1'b0;
                        end else begin
                            // Car left before TLC served it: keep asking
                            state <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (green) begin
                        state <= IDLE;
                        X     <= 1'b0;
                    end
                end

                FAULT: begin
                    if (sync) begin
                        cnt <= '0;
                    end else if (cnt_inc == DEB_FULL) begin
                        state <= IDLE;
                        cnt   <= '0;
                        fault <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    X     <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Bench for vehicle_sensor_conditioner: directed scenarios followed by
// random detector waveforms, scored against a run-length reference model.
`timescale 1ns/1ps
module tb_vehicle_sensor_conditioner;
    import vehicle_sensor_conditioner_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int MAXP = 20;

    logic       clock;
    logic       clear_n;
    logic       sensor_raw;
    logic [1:0] cntry;
    logic       X;
    logic       fault;
    logic [7:0] car_count;

    vehicle_sensor_conditioner #(
        .SYNC_STAGES        (SYNC),
        .DEBOUNCE_CYCLES    (DEB),
        .MAX_PRESENT_CYCLES (MAXP)
    ) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .sensor_raw (sensor_raw),
        .cntry      (cntry),
        .X          (X),
        .fault      (fault),
        .car_count  (car_count)
    );

    // Rising edges at 10, 20, 30 ... ns
    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic       x;
        logic       flt;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The detector as the FSM sees it is sensor_raw delayed by SYNC edges.
    // Behaviour is expressed as run lengths of that delayed signal since
    // entering each mode.
    typedef enum {M_IDLE, M_CAR, M_WAIT, M_STUCK} mmode_t;

    mmode_t m_mode;
    logic   m_pipe [SYNC];
    int     m_ones_idle;
    int     m_ones_car;
    int     m_zeros_car;
    int     m_zeros_stuck;
    bit     m_served;
    int     m_cars;

    function automatic void model_reset();
        m_mode        = M_IDLE;
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
        m_ones_idle   = 0;
        m_ones_car    = 0;
        m_zeros_car   = 0;
        m_zeros_stuck = 0;
        m_served      = 1'b0;
        m_cars        = 0;
    endfunction

    // Advance the model over one rising edge and queue the expected outputs
    function automatic void model_step(input logic raw, input logic [1:0] c);
        logic s;
        bit   green;
        exp_t e;
        s = m_pipe[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = raw;
        green = (c == GREEN);
        case (m_mode)
            M_IDLE: begin
                m_ones_idle = s ? m_ones_idle + 1 : 0;
                if (m_ones_idle == DEB) begin
                    m_mode      = M_CAR;
                    m_cars      = (m_cars + 1) % 256;
                    m_served    = 1'b0;
                    m_ones_car  = 0;
                    m_zeros_car = 0;
                end
            end
            M_CAR: begin
                m_served = m_served || green;
                if (s) begin
                    m_ones_car++;
                    m_zeros_car = 0;
                end else begin
                    m_ones_car = 0;
                    m_zeros_car++;
                end
                if (m_ones_car == MAXP) begin
                    m_mode        = M_STUCK;
                    m_zeros_stuck = 0;
                end else if (m_zeros_car == DEB) begin
                    m_mode      = m_served ? M_IDLE : M_WAIT;
                    m_ones_idle = 0;
                end
            end
            M_WAIT: begin
                if (green) begin
                    m_mode      = M_IDLE;
                    m_ones_idle = 0;
                end
            end
            M_STUCK: begin
                m_zeros_stuck = s ? 0 : m_zeros_stuck + 1;
                if (m_zeros_stuck == DEB) begin
                    m_mode      = M_IDLE;
                    m_ones_idle = 0;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        e.x   = (m_mode == M_CAR) || (m_mode == M_WAIT);
        e.flt = (m_mode == M_STUCK);
        e.cnt = 8'(m_cars);
        sb_q.push_back(e);
    endfunction

    // Drive one cycle of stimulus (on the falling edge) and predict its result
    task automatic step(input logic raw, input logic [1:0] c);
        @(negedge clock);
        sensor_raw = raw;
        cntry      = c;
        model_step(raw, c);
    endtask

    function automatic logic [1:0] pick_cntry();
        if ($urandom_range(0, 7) == 0) return GREEN;
        return ($urandom_range(0, 1) == 0) ? RED : YELLOW;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_x",         32'(X),         32'(e.x));
                check("sb_fault",     32'(fault),     32'(e.flt));
                check("sb_car_count", 32'(car_count), 32'(e.cnt));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic r;
        int   len;

        clear_n    = 1'b0;
        sensor_raw = 1'b0;
        cntry      = RED;
        model_reset();

        // Reset held while the detector chatters
        for (int i = 0; i < 4; i++) begin
            #5;
            sensor_raw = ~sensor_raw;
            check("reset_x",         32'(X),         32'd0);
            check("reset_fault",     32'(fault),     32'd0);
            check("reset_car_count", 32'(car_count), 32'd0);
        end
        #2;                                  // t = 22, between edges
        sensor_raw = 1'b0;
        model_reset();
        clear_n = 1'b1;

        repeat (9) step(1'b0, RED);          // drives at 25 .. 105

        // Clean arrival: raw rises at 115, X must appear after the 170 ns edge
        repeat (6) step(1'b1, RED);          // 115 .. 165
        check("arrival_x_before", 32'(X), 32'd0);
        @(posedge clock); #2;
        check("arrival_x",     32'(X),         32'd1);
        check("arrival_count", 32'(car_count), 32'd1);

        // Served departure: green while present, X falls on the 6th edge after the fall
        step(1'b1, GREEN);
        step(1'b1, GREEN);
        step(1'b1, RED);
        repeat (6) step(1'b0, RED);
        check("served_x_5th_edge", 32'(X), 32'd1);
        @(posedge clock); #2;
        check("served_x_6th_edge", 32'(X), 32'd0);

        // Glitch: three synced cycles high is not a car
        repeat (3) step(1'b1, RED);
        repeat (8) begin
            step(1'b0, RED);
            check("glitch_x", 32'(X), 32'd0);
        end
        check("glitch_count", 32'(car_count), 32'd1);

        // Unserved departure: request is held until the light turns green
        repeat (10) step(1'b1, RED);
        repeat (10) step(1'b0, RED);
        check("hold_x",     32'(X),         32'd1);
        check("hold_count", 32'(car_count), 32'd2);
        step(1'b0, GREEN);
        @(posedge clock); #2;
        check("hold_release_x", 32'(X), 32'd0);

        // Stuck detector: continuous presence trips the fault
        repeat (30) step(1'b1, RED);
        check("stuck_fault", 32'(fault), 32'd1);
        check("stuck_x",     32'(X),     32'd0);
        repeat (6) step(1'b0, RED);
        check("stuck_fault_held", 32'(fault), 32'd1);
        @(posedge clock); #2;
        check("stuck_fault_clear", 32'(fault),     32'd0);
        check("stuck_count",       32'(car_count), 32'd3);

        // Asynchronous reset while a car is present
        repeat (8) step(1'b1, RED);
        check("pre_reset_x", 32'(X), 32'd1);
        #2;
        clear_n = 1'b0;
        sb_q.delete();
        #1;
        check("async_reset_x",     32'(X),         32'd0);
        check("async_reset_fault", 32'(fault),     32'd0);
        check("async_reset_count", 32'(car_count), 32'd0);
        @(posedge clock); #2;
        model_reset();
        clear_n = 1'b1;

        // Random detector waveforms with a mostly-red light
        r = 1'b0;
        for (int seg = 0; seg < 70; seg++) begin
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 4);
            else                           len = $urandom_range(5, 30);
            r = ~r;
            for (int k = 0; k < len; k++) step(r, pick_cntry());
        end

        repeat (2) @(posedge clock);
        #3;
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
